// File: rtl/in_out_pkg.sv
// Shared constants and state encoding for the in_out stimulus sequencer.
package in_out_pkg;

    localparam int VEC_W = 3;  // {in_1,in_2,in_3}
    localparam int CAP_W = 2;  // {out_1,out_2}

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/in_out_vec_mem.sv
// Stimulus vector table: NUM_VEC x VEC_W registers, one write port, one
// combinational read port.
module in_out_vec_mem
    import in_out_pkg::*;
#(
    parameter int NUM_VEC = 4,
    parameter int ADDR_W  = $clog2(NUM_VEC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [VEC_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [VEC_W-1:0]  rd_data
);

    logic [VEC_W-1:0] mem [NUM_VEC];
    logic             wr_ok;
    logic             rd_ok;

    // Address range guards only matter when NUM_VEC is not a power of two.
    if (NUM_VEC == (1 << ADDR_W)) begin : g_full
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_part
        assign wr_ok = (int'(wr_addr) < NUM_VEC);
        assign rd_ok = (int'(rd_addr) < NUM_VEC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/in_out_seq.sv
// Applies each stored vector to the in_out datapath for a latched dwell time
// and captures the datapath response at the end of every dwell.
module in_out_seq
    import in_out_pkg::*;
#(
    parameter int NUM_VEC = 4,
    parameter int DWELL_W = 8,
    localparam int ADDR_W = $clog2(NUM_VEC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               vec_wr_en,
    input  logic [ADDR_W-1:0]  vec_wr_addr,
    input  logic [VEC_W-1:0]   vec_wr_data,
    input  logic               out_1,
    input  logic               out_2,
    output logic               in_1,
    output logic               in_2,
    output logic               in_3,
    output logic               busy,
    output logic               done,
    output logic               cap_valid,
    output logic [ADDR_W-1:0]  cap_addr,
    output logic [CAP_W-1:0]   cap_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  vec_idx;
    logic [ADDR_W-1:0]  rd_addr;
    logic [VEC_W-1:0]   rd_data;
    logic [VEC_W-1:0]   vec_q;
    logic [DWELL_W-1:0] dwell_lat;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               last_cycle;
    logic               last_vec;
    logic               run_go;

    // Counter runs 0..dwell_lat-1, so the largest dwell never needs to wrap.
    assign last_cycle = (dwell_cnt == dwell_lat - DWELL_W'(1));
    assign last_vec   = (vec_idx == LAST_IDX);
    assign run_go     = start && !abort;
    // Read the vector that the next register load will present.
    assign rd_addr    = (state == ST_APPLY) ? vec_idx + ADDR_W'(1) : '0;

    in_out_vec_mem #(
        .NUM_VEC (NUM_VEC),
        .ADDR_W  (ADDR_W)
    ) u_vec_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vec_wr_en && !busy),
        .wr_addr (vec_wr_addr),
        .wr_data (vec_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (run_go) state_next = ST_APPLY;
            ST_APPLY: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_cycle && last_vec) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_APPLY);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_idx   <= '0;
            vec_q     <= '0;
            dwell_lat <= '0;
            dwell_cnt <= '0;
            cap_valid <= 1'b0;
            cap_addr  <= '0;
            cap_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cap_valid <= 1'b0;
                    if (run_go) begin
                        dwell_lat <= (dwell == '0) ? DWELL_W'(1) : dwell;
                        dwell_cnt <= '0;
                        vec_idx   <= '0;
                        vec_q     <= rd_data;
                    end
                end
                ST_APPLY: begin
                    if (abort) begin
                        cap_valid <= 1'b0;
                        vec_q     <= '0;
                        vec_idx   <= '0;
                        dwell_cnt <= '0;
                    end else if (last_cycle) begin
                        cap_valid <= 1'b1;
                        cap_addr  <= vec_idx;
                        cap_data  <= {out_1, out_2};
                        dwell_cnt <= '0;
                        if (last_vec) begin
                            vec_q <= '0;
                        end else begin
                            vec_q   <= rd_data;
                            vec_idx <= vec_idx + ADDR_W'(1);
                        end
                    end else begin
                        cap_valid <= 1'b0;
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    cap_valid <= 1'b0;
                    vec_q     <= '0;
                    vec_idx   <= '0;
                end
            endcase
        end
    end

    assign in_1 = vec_q[2];
    assign in_2 = vec_q[1];
    assign in_3 = vec_q[0];

endmodule

// File: tb/tb_in_out_seq.sv
// Self-checking bench for in_out_seq against a cycle-indexed behavioural model
// of a run (vector k held on cycles k*D+1 .. (k+1)*D, done on cycle N*D+1).
module tb_in_out_seq;

    localparam int NUM_VEC = 4;
    localparam int DWELL_W = 8;
    localparam int ADDR_W  = $clog2(NUM_VEC);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic               vec_wr_en = 1'b0;
    logic [ADDR_W-1:0]  vec_wr_addr = '0;
    logic [2:0]         vec_wr_data = '0;
    logic               out_1, out_2, in_1, in_2, in_3;
    logic               busy, done, cap_valid;
    logic [ADDR_W-1:0]  cap_addr;
    logic [1:0]         cap_data;

    int checks   = 0;
    int failures = 0;

    logic [2:0]        ref_tab [NUM_VEC];
    logic [ADDR_W+1:0] exp_q [$];

    always #5 clk = ~clk;

    // Datapath model sitting between the sequencer outputs and inputs.
    assign out_1 = in_1 & in_2;
    assign out_2 = in_2 | in_3;

    in_out_seq #(.NUM_VEC(NUM_VEC), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dwell(dwell),
        .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
        .out_1(out_1), .out_2(out_2), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .busy(busy), .done(done), .cap_valid(cap_valid),
        .cap_addr(cap_addr), .cap_data(cap_data)
    );

    // ---------------- reference model ----------------
    function automatic logic [1:0] dp(input logic [2:0] v);
        return {v[2] & v[1], v[1] | v[0]};
    endfunction

    // Expected {busy,done,cap_valid,in_1,in_2,in_3} on cycle t after a start
    // sampled at edge 0 with effective dwell d; abort sampled at edge a (0 = none).
    function automatic logic [5:0] m_ctrl(input int t, input int d, input int a);
        int n;
        logic [5:0] r;
        n = NUM_VEC * d;
        r = '0;
        if (a > 0 && t > a) return '0;
        if (t >= 1 && t <= n) begin
            r[5]   = 1'b1;
            r[2:0] = ref_tab[(t - 1) / d];
        end
        if (t == n + 1) r[4] = 1'b1;
        if (t > d && t <= n + 1 && (t - 1) % d == 0) r[3] = 1'b1;
        return r;
    endfunction

    // Capture k appears on cycle (k+1)*d+1 and survives only if not aborted first.
    task automatic fill_exp(input int d, input int a);
        exp_q.delete();
        for (int k = 0; k < NUM_VEC; k++) begin
            if (a == 0 || (k + 1) * d + 1 <= a) begin
                exp_q.push_back({ADDR_W'(k), dp(ref_tab[k])});
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_vec(input int addr, input logic [2:0] data);
        vec_wr_en   = 1'b1;
        vec_wr_addr = ADDR_W'(addr);
        vec_wr_data = data;
        @(posedge clk); #1;
        vec_wr_en = 1'b0;
        ref_tab[addr] = data;
    endtask

    task automatic load_table(input logic [2:0] v0, input logic [2:0] v1,
                              input logic [2:0] v2, input logic [2:0] v3);
        write_vec(0, v0);
        write_vec(1, v1);
        write_vec(2, v2);
        write_vec(3, v3);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [5:0] obs, exp_v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, cap_valid, in_1, in_2, in_3, cap_addr, cap_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b%b%b %b %b required=all zero",
                     busy, done, cap_valid, in_1, in_2, in_3, cap_addr, cap_data);
        end
        rst = 1'b0;
        for (int i = 0; i < NUM_VEC; i++) ref_tab[i] = '0;
        // A run on the untouched table must present and capture only zeros.
        fill_exp(1, 0);
        dwell = 8'd1;
        start = 1'b1;
        for (int t = 1; t <= NUM_VEC + 3; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            obs   = {busy, done, cap_valid, in_1, in_2, in_3};
            exp_v = m_ctrl(t, 1, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL reset_table_ctrl t=%0d got=%b required=%b", t, obs, exp_v);
            end
            if (cap_valid && exp_q.size() > 0) begin
                checks++;
                if ({cap_addr, cap_data} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL reset_table_cap got=%b required=%b", {cap_addr, cap_data}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_basic();
        logic [5:0] obs, exp_v;
        load_table(3'b000, 3'b110, 3'b011, 3'b101);
        fill_exp(3, 0);
        dwell = 8'd3;
        start = 1'b1;
        for (int t = 1; t <= 4 * 3 + 3; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            obs   = {busy, done, cap_valid, in_1, in_2, in_3};
            exp_v = m_ctrl(t, 3, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL basic_ctrl t=%0d got=%b required=%b", t, obs, exp_v);
            end
            if (cap_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL basic_cap t=%0d got=%b required=none", t, {cap_addr, cap_data});
                end else begin
                    if ({cap_addr, cap_data} !== exp_q[0]) begin
                        failures++;
                        $display("FAIL basic_cap t=%0d got=%b required=%b", t, {cap_addr, cap_data}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_cap_count missing=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_dwell_zero();
        logic [5:0] obs, exp_v;
        load_table(3'b111, 3'b001, 3'b100, 3'b010);
        dwell = 8'd0;
        start = 1'b1;
        for (int t = 1; t <= NUM_VEC + 3; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            obs   = {busy, done, cap_valid, in_1, in_2, in_3};
            exp_v = m_ctrl(t, 1, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL dwell0_ctrl t=%0d got=%b required=%b", t, obs, exp_v);
            end
            if (exp_v[3]) begin
                checks++;
                if ({cap_addr, cap_data} !== {ADDR_W'(t - 2), dp(ref_tab[t - 2])}) begin
                    failures++;
                    $display("FAIL dwell0_cap t=%0d got=%b required=%b", t, {cap_addr, cap_data},
                             {ADDR_W'(t - 2), dp(ref_tab[t - 2])});
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [5:0] obs, exp_v;
        int ncap;
        load_table(3'b000, 3'b110, 3'b011, 3'b101);
        dwell = 8'd3;
        start = 1'b1;
        ncap  = 0;
        for (int t = 1; t <= 16; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            obs   = {busy, done, cap_valid, in_1, in_2, in_3};
            exp_v = m_ctrl(t, 3, 5);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL abort_ctrl t=%0d got=%b required=%b", t, obs, exp_v);
            end
            if (cap_valid) ncap++;
            if (t == 5) abort = 1'b1;
        end
        // Only the capture landing on cycle 4 precedes the abort edge.
        checks++;
        if (ncap != 1) begin
            failures++;
            $display("FAIL abort_cap_count got=%0d required=1", ncap);
        end
    endtask

    task automatic test_abort_priority();
        logic [5:0] obs;
        start = 1'b1;
        abort = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk); #1;
            obs = {busy, done, cap_valid, in_1, in_2, in_3};
            checks++;
            if (obs !== 6'b0) begin
                failures++;
                $display("FAIL abort_priority t=%0d got=%b required=000000", t, obs);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_busy_ignore();
        logic [5:0] obs, exp_v;
        int n, ndone;
        load_table(3'b101, 3'b010, 3'b110, 3'b001);
        n     = NUM_VEC * 2;
        dwell = 8'd2;
        start = 1'b1;
        ndone = 0;
        for (int t = 1; t <= n + 6; t++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            vec_wr_en = 1'b0;
            obs   = {busy, done, cap_valid, in_1, in_2, in_3};
            exp_v = m_ctrl(t, 2, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL busy_ctrl t=%0d got=%b required=%b", t, obs, exp_v);
            end
            if (done) ndone++;
            if (t == 2 || t == n) begin
                vec_wr_en   = 1'b1;
                vec_wr_addr = ADDR_W'($urandom_range(0, NUM_VEC - 1));
                vec_wr_data = 3'($urandom_range(0, 7));
            end
            if (t == 3) start = 1'b1;
            if (t == n + 1) begin
                // Write landing in DONE is accepted.
                vec_wr_en   = 1'b1;
                vec_wr_addr = '0;
                vec_wr_data = 3'b111;
                ref_tab[0]  = 3'b111;
            end
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL busy_done_count got=%0d required=1", ndone);
        end
        // Replay at dwell 1 to read the table back through in_*.
        dwell = 8'd1;
        start = 1'b1;
        for (int t = 1; t <= NUM_VEC + 2; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            obs   = {busy, done, cap_valid, in_1, in_2, in_3};
            exp_v = m_ctrl(t, 1, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL busy_table t=%0d got=%b required=%b", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [5:0] obs, exp_v;
        load_table(3'b000, 3'b110, 3'b011, 3'b101);
        dwell = 8'd3;
        start = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            obs   = {busy, done, cap_valid, in_1, in_2, in_3};
            exp_v = m_ctrl(t, 3, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL rstmid_pre t=%0d got=%b required=%b", t, obs, exp_v);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cap_valid, in_1, in_2, in_3, cap_addr, cap_data} !== '0) begin
            failures++;
            $display("FAIL rstmid_immediate got=%b%b%b%b%b%b %b %b required=all zero",
                     busy, done, cap_valid, in_1, in_2, in_3, cap_addr, cap_data);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_VEC; i++) ref_tab[i] = '0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, done, cap_valid, in_1, in_2, in_3} !== 6'b0) begin
                failures++;
                $display("FAIL rstmid_after t=%0d got=%b%b%b%b%b%b required=000000",
                         t, busy, done, cap_valid, in_1, in_2, in_3);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] obs, exp_v;
        int d, dw, a, n;
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < NUM_VEC; i++) write_vec(i, 3'($urandom_range(0, 7)));
            // First run exercises the largest dwell without wrap.
            dw = (run == 0) ? 255 : $urandom_range(0, 6);
            d  = (dw == 0) ? 1 : dw;
            n  = NUM_VEC * d;
            a  = ($urandom_range(0, 1) == 1 && run != 0) ? $urandom_range(1, n) : 0;
            fill_exp(d, a);
            dwell = DWELL_W'(dw);
            start = 1'b1;
            for (int t = 1; t <= n + 3; t++) begin
                @(posedge clk); #1;
                start = 1'b0;
                abort = 1'b0;
                obs   = {busy, done, cap_valid, in_1, in_2, in_3};
                exp_v = m_ctrl(t, d, a);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL rand_ctrl run=%0d dwell=%0d abort=%0d t=%0d got=%b required=%b",
                             run, dw, a, t, obs, exp_v);
                end
                if (cap_valid && exp_q.size() > 0) begin
                    checks++;
                    if ({cap_addr, cap_data} !== exp_q[0]) begin
                        failures++;
                        $display("FAIL rand_cap run=%0d t=%0d got=%b required=%b",
                                 run, t, {cap_addr, cap_data}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (t == a) abort = 1'b1;
            end
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL rand_cap_count run=%0d missing=%0d required=0", run, exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dwell_zero();
        test_abort();
        test_abort_priority();
        test_busy_ignore();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
